// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - sweeps a 2-input gate through all vectors and checks its truth table
// Optional error capture enabled by GATE_SWEEP_ERR_CAPTURE_EN (adds err_valid / err_idx).
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] exp_tt,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] obs_tt
`ifdef GATE_SWEEP_ERR_CAPTURE_EN
    ,
    output logic       err_valid,
    output logic [1:0] err_idx
`endif
);

    // SETTLE_CYCLES must be >= 1; the counter holds SETTLE_CYCLES-1 down to 0.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      idx;
    logic [CW-1:0]   cnt;
    logic [3:0]      exp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_WAIT;
            S_WAIT:   if (cnt == '0) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = (idx == 2'd3) ? S_IDLE : S_WAIT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= 2'd0;
            cnt    <= '0;
            exp_q  <= 4'd0;
            dut_a  <= 1'b0;
            dut_b  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
            obs_tt <= 4'd0;
`ifdef GATE_SWEEP_ERR_CAPTURE_EN
            err_valid <= 1'b0;
            err_idx   <= 2'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        exp_q  <= exp_tt;
                        idx    <= 2'd0;
                        dut_a  <= 1'b0;
                        dut_b  <= 1'b0;
                        cnt    <= RELOAD;
                        obs_tt <= 4'd0;
                        pass   <= 1'b0;
                        busy   <= 1'b1;
`ifdef GATE_SWEEP_ERR_CAPTURE_EN
                        err_valid <= 1'b0;
                        err_idx   <= 2'd0;
`endif
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                S_SAMPLE: begin
                    obs_tt[idx] <= dut_o;
`ifdef GATE_SWEEP_ERR_CAPTURE_EN
                    // Only the first mismatching vector is recorded.
                    if (!err_valid && (dut_o != exp_q[idx])) begin
                        err_valid <= 1'b1;
                        err_idx   <= idx;
                    end
`endif
                    if (idx != 2'd3) begin
                        idx           <= idx + 2'd1;
                        {dut_a, dut_b} <= idx + 2'd1;
                        cnt           <= RELOAD;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        // obs_tt[3] is written this same edge, so use dut_o directly.
                        pass <= ({dut_o, obs_tt[2:0]} == exp_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - scoreboard bench for gate_sweep_checker (SETTLE_CYCLES 1 and 3)
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic [3:0] exp1 = 4'd0, exp3 = 4'd0;
    logic       sel1 = 1'b0, sel3 = 1'b0;
    logic       a1, b1, o1, busy1, done1, pass1;
    logic       a3, b3, o3, busy3, done3, pass3;
    logic [3:0] obs1, obs3;
`ifdef GATE_SWEEP_ERR_CAPTURE_EN
    logic       ev1, ev3;
    logic [1:0] ei1, ei3;
`endif

    int checks = 0;
    int errors = 0;
    int dones1 = 0;
    int dones3 = 0;

    typedef struct {
        logic [3:0] obs;
        logic       pass;
        logic       ev;
        logic [1:0] ei;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t m1, m3;

    always #5 clk = ~clk;

    // Gate models: sel=0 AND, sel=1 OR
    assign o1 = sel1 ? (a1 | b1) : (a1 & b1);
    assign o3 = sel3 ? (a3 | b3) : (a3 & b3);

    gate_sweep_checker #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_tt(exp1),
        .dut_a(a1), .dut_b(b1), .dut_o(o1),
        .busy(busy1), .done(done1), .pass(pass1), .obs_tt(obs1)
`ifdef GATE_SWEEP_ERR_CAPTURE_EN
        , .err_valid(ev1), .err_idx(ei1)
`endif
    );

    gate_sweep_checker #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .exp_tt(exp3),
        .dut_a(a3), .dut_b(b3), .dut_o(o3),
        .busy(busy3), .done(done3), .pass(pass3), .obs_tt(obs3)
`ifdef GATE_SWEEP_ERR_CAPTURE_EN
        , .err_valid(ev3), .err_idx(ei3)
`endif
    );

    function automatic exp_t model(input logic [3:0] e, input logic or_g);
        exp_t r;
        r.ev  = 1'b0;
        r.ei  = 2'd0;
        r.obs = 4'd0;
        for (int i = 0; i < 4; i++) begin
            r.obs[i] = or_g ? (i[1] | i[0]) : (i[1] & i[0]);
            if (!r.ev && (r.obs[i] != e[i])) begin
                r.ev = 1'b1;
                r.ei = 2'(i);
            end
        end
        r.pass = (r.obs == e);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done1) begin
            dones1++;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done1 got done=1 required no done");
            end else begin
                m1 = q1.pop_front();
                if (pass1 !== m1.pass) begin
                    errors++;
                    $display("FAIL pass1 got %b required %b", pass1, m1.pass);
                end
                checks++;
                if (obs1 !== m1.obs) begin
                    errors++;
                    $display("FAIL obs_tt1 got %b required %b", obs1, m1.obs);
                end
`ifdef GATE_SWEEP_ERR_CAPTURE_EN
                checks++;
                if (ev1 !== m1.ev || (m1.ev && ei1 !== m1.ei)) begin
                    errors++;
                    $display("FAIL err1 got %b/%b required %b/%b", ev1, ei1, m1.ev, m1.ei);
                end
`endif
            end
        end
        if (rst_n && done3) begin
            dones3++;
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done3 got done=1 required no done");
            end else begin
                m3 = q3.pop_front();
                if (pass3 !== m3.pass) begin
                    errors++;
                    $display("FAIL pass3 got %b required %b", pass3, m3.pass);
                end
                checks++;
                if (obs3 !== m3.obs) begin
                    errors++;
                    $display("FAIL obs_tt3 got %b required %b", obs3, m3.obs);
                end
`ifdef GATE_SWEEP_ERR_CAPTURE_EN
                checks++;
                if (ev3 !== m3.ev || (m3.ev && ei3 !== m3.ei)) begin
                    errors++;
                    $display("FAIL err3 got %b/%b required %b/%b", ev3, ei3, m3.ev, m3.ei);
                end
`endif
            end
        end
    end

    // Returns at 1ns after the accepting edge E0.
    task automatic start_u1(input logic [3:0] e, input logic g, input bit push);
        @(negedge clk);
        exp1   = e;
        sel1   = g;
        start1 = 1'b1;
        if (push) q1.push_back(model(e, g));
        @(posedge clk);
        #1 start1 = 1'b0;
    endtask

    task automatic start_u3(input logic [3:0] e, input logic g);
        @(negedge clk);
        exp3   = e;
        sel3   = g;
        start3 = 1'b1;
        q3.push_back(model(e, g));
        @(posedge clk);
        #1 start3 = 1'b0;
    endtask

    task automatic wait_q1_empty(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy1, done1, pass1, obs1, a1, b1} !== 9'd0) begin
            errors++;
            $display("FAIL reset_state got %b required 000000000", {busy1, done1, pass1, obs1, a1, b1});
        end
`ifdef GATE_SWEEP_ERR_CAPTURE_EN
        checks++;
        if ({ev1, ei1} !== 3'd0) begin
            errors++;
            $display("FAIL reset_err got %b required 000", {ev1, ei1});
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_and_pass;
        logic [1:0] v;
        start_u1(4'b1000, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            v = (c >= 8) ? 2'd3 : 2'(c / 2);
            checks++;
            if ({a1, b1} !== v) begin
                errors++;
                $display("FAIL and_vector c=%0d got %b required %b", c, {a1, b1}, v);
            end
            checks++;
            if (done1 !== (c == 8)) begin
                errors++;
                $display("FAIL and_done_timing c=%0d got %b required %b", c, done1, (c == 8));
            end
            checks++;
            if (busy1 !== (c < 8)) begin
                errors++;
                $display("FAIL and_busy c=%0d got %b required %b", c, busy1, (c < 8));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_and_fail;
        bit ok;
        start_u1(4'b1110, 1'b0, 1'b1);
        wait_q1_empty(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL and_fail_timeout got pending=%0d required 0", q1.size());
        end
    endtask

    task automatic test_start_ignored;
        int d0;
        d0 = dones1;
        start_u1(4'b1000, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        start1 = 1'b1;
        exp1   = 4'b0000;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        checks++;
        if (dones1 - d0 != 1) begin
            errors++;
            $display("FAIL start_ignored_done_count got %0d required 1", dones1 - d0);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int d0;
        bit ok;
        start_u1(4'b1000, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_busy got %b required 1", busy1);
        end
        d0 = dones1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy1, a1, b1, obs1, done1, pass1} !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid_sweep got %b required 000000000", {busy1, a1, b1, obs1, done1, pass1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        checks++;
        if (dones1 != d0) begin
            errors++;
            $display("FAIL reset_no_done got %0d required 0", dones1 - d0);
        end
        start_u1(4'b1000, 1'b0, 1'b1);
        wait_q1_empty(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL after_reset_timeout got pending=%0d required 0", q1.size());
        end
    endtask

    task automatic test_settle3_or;
        logic [1:0] v;
        start_u3(4'b1110, 1'b1);
        for (int c = 0; c < 18; c++) begin
            v = (c >= 16) ? 2'd3 : 2'(c / 4);
            checks++;
            if ({a3, b3} !== v) begin
                errors++;
                $display("FAIL s3_vector c=%0d got %b required %b", c, {a3, b3}, v);
            end
            checks++;
            if (done3 !== (c == 16)) begin
                errors++;
                $display("FAIL s3_done_timing c=%0d got %b required %b", c, done3, (c == 16));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back;
        bit seen;
        start_u1(4'b1000, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_first_done got none required done");
        end
        exp1   = 4'b1110;
        start1 = 1'b1;
        q1.push_back(model(4'b1110, 1'b0));
        @(posedge clk);
        #1 start1 = 1'b0;
        checks++;
        if ({busy1, pass1, obs1} !== 6'b100000) begin
            errors++;
            $display("FAIL b2b_accept got %b required 100000", {busy1, pass1, obs1});
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done1 !== (c == 8)) begin
                errors++;
                $display("FAIL b2b_done_timing c=%0d got %b required %b", c, done1, (c == 8));
            end
        end
    endtask

    initial begin
        test_reset;
        test_and_pass;
        test_and_fail;
        test_start_ignored;
        test_reset_mid_sweep;
        test_settle3_or;
        test_back_to_back;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d required 0/0", q1.size(), q3.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
